// File: rtl/neuron_mac_ctrl.sv
// rtl/neuron_mac_ctrl.sv - sequencer for one neuron multiply-accumulate evaluation.
// Optional cancel input guarded by NEURON_CTRL_ABORT_EN.
module neuron_mac_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int MULT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_inputs,
`ifdef NEURON_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              init,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              ld_reg,
    output logic              act_en,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_DRAIN,
        S_ACT,
        S_DONE
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'((MULT_LAT > 0) ? MULT_LAT - 1 : 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        drain_q, drain_d;
    logic              abort_req;

`ifdef NEURON_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = n_inputs;
                    idx_d   = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                idx_d   = '0;
                state_d = (count_q != '0) ? S_ISSUE : S_ACT;
            end
            S_ISSUE: begin
                if (idx_q == count_q - ADDR_W'(1)) begin
                    idx_d   = '0;
                    drain_d = '0;
                    state_d = (MULT_LAT > 0) ? S_DRAIN : S_ACT;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_ACT;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            S_ACT:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Cancel wins over every other transition, but only once a run is in flight.
        if (abort_req && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            drain_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign init       = (state_q == S_INIT);
    assign addr_valid = (state_q == S_ISSUE);
    assign addr       = addr_valid ? idx_q : '0;
    assign act_en     = (state_q == S_ACT) && !abort_req;
    assign done       = (state_q == S_DONE) && !abort_req;

    // ld_reg tracks addr_valid through the multiplier pipeline depth.
    if (MULT_LAT == 0) begin : g_no_lat
        assign ld_reg = addr_valid;
    end else begin : g_lat
        logic [MULT_LAT-1:0] ld_sr_q, ld_sr_d;

        always_comb begin
            ld_sr_d = '0;
            if (!(abort_req && busy)) begin
                ld_sr_d[0] = addr_valid;
                for (int i = 1; i < MULT_LAT; i++) begin
                    ld_sr_d[i] = ld_sr_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ld_sr_q <= '0;
            end else begin
                ld_sr_q <= ld_sr_d;
            end
        end

        assign ld_reg = ld_sr_q[MULT_LAT-1];
    end

endmodule

// File: doc/neuron_mac_ctrl.md
NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: width of the term index and of the term count.
REQ-002 Parameter MULT_LAT, default 1, legal 0..3: cycles from addr_valid until the product reaches the accumulator input.
REQ-003 Port clk  in  1  single clock; all state on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port start  in  1  request to begin one neuron evaluation.
REQ-006 Port n_inputs  in  ADDR_W  number of input/weight terms; sampled on accepted start.
REQ-007 Port busy  out  1  high in every state except IDLE.
REQ-008 Port init  out  1  accumulator bias-preload strobe.
REQ-009 Port addr  out  ADDR_W  index of the input/weight pair currently issued.
REQ-010 Port addr_valid  out  1  addr is valid this cycle.
REQ-011 Port ld_reg  out  1  accumulator load enable.
REQ-012 Port act_en  out  1  capture strobe for the activation stage.
REQ-013 Port done  out  1  single-cycle completion pulse.
REQ-014 Port abort  in  1  cancel request; present only under REQ-030.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, ISSUE, DRAIN, ACT, DONE.
REQ-016 IDLE: start=1 SHALL be accepted, n_inputs latched, next state INIT; start in any other state SHALL be ignored.
REQ-017 INIT: init=1 for exactly one cycle; next state ISSUE if latched count>0, else ACT.
REQ-018 ISSUE: addr_valid=1, addr=0,1,...,count-1, one per cycle, no gaps; after index count-1 the next state SHALL be DRAIN if MULT_LAT>0, else ACT.
REQ-019 ld_reg SHALL equal addr_valid delayed by exactly MULT_LAT cycles through a shift register; MULT_LAT=0 gives ld_reg=addr_valid in the same cycle.
REQ-020 DRAIN SHALL last exactly MULT_LAT cycles, then ACT.
REQ-021 ACT: act_en=1 for one cycle, strictly after the last ld_reg cycle; next DONE.
REQ-022 DONE: done=1 for one cycle; next IDLE; a start in this cycle SHALL be ignored.
REQ-023 Latency, start accepted at edge 0: init in cycle 1, addr k in cycle k+2, ld_reg for term k in cycle k+2+MULT_LAT, act_en in cycle count+2+MULT_LAT, done in cycle count+3+MULT_LAT; for count=0, act_en in cycle 2 and done in cycle 3.
REQ-024 count = 2^ADDR_W-1 SHALL issue all indices without wrap; addr SHALL hold 0 whenever addr_valid=0.
REQ-025 init, ld_reg, act_en and done SHALL be mutually exclusive in any cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, clear the latched count, addr counter and ld_reg shift register.
REQ-027 During reset and in the first cycle after it, busy, init, addr, addr_valid, ld_reg, act_en and done SHALL all be 0.
REQ-028 Reset asserted mid-evaluation SHALL discard that evaluation with no done pulse; a start following deassertion SHALL run normally.
REQ-029 Release of rst_n SHALL be synchronous to clk; rst_n is assumed synchronized externally.

Configuration
REQ-030 Macro NEURON_CTRL_ABORT_EN defined: port abort exists; abort=1 sampled in any non-IDLE state SHALL move to IDLE at the next edge, clear the ld_reg shift register and suppress act_en and done; abort in IDLE has no effect; abort takes priority over every other transition.
REQ-031 Macro not defined: no abort port; an evaluation runs to DONE once started.

Verification
REQ-032 ADDR_W=8, MULT_LAT=1, n_inputs=4, start pulse at cycle 0 -> init cycle 1, addr 0..3 cycles 2..5, ld_reg cycles 3..6, act_en cycle 7, done cycle 8, busy cycles 1..8.
REQ-033 MULT_LAT=0, n_inputs=3 -> ld_reg coincident with addr_valid in cycles 2..4, no DRAIN, act_en cycle 5, done cycle 6.
REQ-034 n_inputs=0 -> init cycle 1, no addr_valid/ld_reg, act_en cycle 2, done cycle 3.
REQ-035 MULT_LAT=3, n_inputs=5, start held high through the run, then n_inputs changed to 2 mid-run -> exactly 5 terms, done at cycle 11, no second evaluation started from the held start until the cycle after done.
REQ-036 rst_n pulled low at cycle 4 of an n_inputs=6 run -> all outputs 0 asynchronously, no done; a restart with n_inputs=2 completes with done at cycle 6 (MULT_LAT=1).
REQ-037 NEURON_CTRL_ABORT_EN, MULT_LAT=2, n_inputs=4, abort at cycle 4 -> busy=0 and ld_reg=0 from cycle 5, no act_en or done.
